// File: rtl/rv32_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// FSM states, opcodes, and the datapath control field encodings.
package rv32_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_U = 3'b001;
    localparam logic [2:0] EXT_S = 3'b010;
    localparam logic [2:0] EXT_B = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    localparam logic [1:0] ALUB_RS2  = 2'b00;
    localparam logic [1:0] ALUB_IMM  = 2'b01;
    localparam logic [1:0] ALUB_FOUR = 2'b10;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_COPYB = 4'b0011;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;

    typedef struct packed {
        logic [2:0] extop;
        logic       alua;
        logic [1:0] alub;
        logic [3:0] aluctr;
        logic [2:0] branch;
        logic       regwr;
        logic       mem2reg;
        logic       memwr;
        logic [2:0] memop;
    } dec_t;

    // alt selects the sub/sra variant; everything else passes {alt,func3} through
    function automatic logic [3:0] alu_arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_arith = alt ? ALU_SUB : ALU_ADD;
            3'b010:  alu_arith = ALU_SLT;
            3'b011:  alu_arith = ALU_SLTU;
            default: alu_arith = {alt, f3};
        endcase
    endfunction

endpackage

// File: rtl/rv32_ctrl_decode.sv
// Combinational instruction decoder: opcode/func3/func7 to datapath control
// fields plus the class flags the sequencer needs.
module rv32_ctrl_decode
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] i_op,
    input  logic [2:0] i_func3,
    input  logic [6:0] i_func7,
    output dec_t       o_dec,
    output logic       o_is_load,
    output logic       o_is_store,
    output logic       o_legal
);

    logic w_alt;

    // only the exact 0100000 pattern selects sub/sra
    assign w_alt = (i_func7 == 7'b0100000);

    always_comb begin
        o_dec       = '0;
        o_dec.memop = i_func3;
        o_is_load   = 1'b0;
        o_is_store  = 1'b0;
        o_legal     = 1'b1;
        case (i_op)
            OP_LUI: begin
                o_dec.extop  = EXT_U;
                o_dec.alub   = ALUB_IMM;
                o_dec.aluctr = ALU_COPYB;
                o_dec.regwr  = 1'b1;
            end
            OP_AUIPC: begin
                o_dec.extop  = EXT_U;
                o_dec.alua   = 1'b1;
                o_dec.alub   = ALUB_IMM;
                o_dec.aluctr = ALU_ADD;
                o_dec.regwr  = 1'b1;
            end
            OP_JAL: begin
                o_dec.extop  = EXT_J;
                o_dec.alua   = 1'b1;
                o_dec.alub   = ALUB_FOUR;
                o_dec.aluctr = ALU_ADD;
                o_dec.branch = BR_JAL;
                o_dec.regwr  = 1'b1;
            end
            OP_JALR: begin
                o_dec.extop  = EXT_I;
                o_dec.alua   = 1'b1;
                o_dec.alub   = ALUB_FOUR;
                o_dec.aluctr = ALU_ADD;
                o_dec.branch = BR_JALR;
                o_dec.regwr  = 1'b1;
            end
            OP_BRANCH: begin
                o_dec.extop  = EXT_B;
                o_dec.alub   = ALUB_RS2;
                // eq/ne test the zero flag of a subtract, lt/ge use slt(u)
                o_dec.aluctr = i_func3[2] ? (i_func3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                o_dec.branch = {1'b1, i_func3[2], i_func3[0]};
            end
            OP_LOAD: begin
                o_dec.extop   = EXT_I;
                o_dec.alub    = ALUB_IMM;
                o_dec.aluctr  = ALU_ADD;
                o_dec.regwr   = 1'b1;
                o_dec.mem2reg = 1'b1;
                o_is_load     = 1'b1;
            end
            OP_STORE: begin
                o_dec.extop  = EXT_S;
                o_dec.alub   = ALUB_IMM;
                o_dec.aluctr = ALU_ADD;
                o_dec.memwr  = 1'b1;
                o_is_store   = 1'b1;
            end
            OP_IMM: begin
                o_dec.extop  = EXT_I;
                o_dec.alub   = ALUB_IMM;
                // func7 is immediate data except for the right-shift variants
                o_dec.aluctr = alu_arith(i_func3, (i_func3 == 3'b101) && w_alt);
                o_dec.regwr  = 1'b1;
            end
            OP_REG: begin
                o_dec.alub   = ALUB_RS2;
                o_dec.aluctr = alu_arith(i_func3, w_alt);
                o_dec.regwr  = 1'b1;
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// wait timeout and sticky fault. Define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes.
module rv32i_multicycle_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic [2:0] extop,
    output logic       ALUAsrc,
    output logic [1:0] ALUBsrc,
    output logic [3:0] ALUctr,
    output logic [2:0] branch,
    output logic       regwr,
    output logic       mem2reg,
    output logic       memwr,
    output logic [2:0] memop,
    output logic       fault,
    output logic [2:0] state
);

    localparam logic [TO_W-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? TO_W'(MEM_TIMEOUT - 1) : '0;

    state_t          r_state, w_next;
    logic [TO_W-1:0] r_wait;
    logic            r_fault;
    logic            w_fault_set, w_dec_vld, w_to_lim;
    logic            w_is_load, w_is_store, w_legal;
    dec_t            w_dec, w_dec_g;

    rv32_ctrl_decode u_decode (
        .i_op       (op),
        .i_func3    (func3),
        .i_func7    (func7),
        .o_dec      (w_dec),
        .o_is_load  (w_is_load),
        .o_is_store (w_is_store),
        .o_legal    (w_legal)
    );

    assign w_to_lim = (MEM_TIMEOUT != 0) && (r_wait == TO_LAST);

    always_comb begin
        w_next      = r_state;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        ir_wr       = 1'b0;
        pc_wr       = 1'b0;
        regwr       = 1'b0;
        memwr       = 1'b0;
        w_fault_set = 1'b0;
        w_dec_vld   = 1'b0;
        case (r_state)
            S_FETCH: begin
                // rst_n gate keeps the request low for the whole reset interval
                if (rst_n) begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_wr  = 1'b1;
                        w_next = S_DECODE;
                    end else if (w_to_lim) begin
                        w_fault_set = 1'b1;
                        w_next      = S_HALT;
                    end
                end
            end
            S_DECODE: begin
                w_dec_vld = 1'b1;
                w_next    = S_EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (!w_legal) begin
                    w_dec_vld   = 1'b0;
                    w_fault_set = 1'b1;
                    w_next      = S_HALT;
                end
`endif
            end
            S_EXEC: begin
                w_dec_vld = 1'b1;
                if (w_is_load || w_is_store) begin
                    w_next = S_MEM;
                end else if (w_dec.regwr && w_legal) begin
                    w_next = S_WB;
                end else begin
                    // branches and unknown ops retire here
                    pc_wr  = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_MEM: begin
                w_dec_vld = 1'b1;
                dmem_req  = 1'b1;
                memwr     = w_dec.memwr;
                if (dmem_ack) begin
                    if (w_is_store) begin
                        pc_wr  = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_to_lim) begin
                    w_fault_set = 1'b1;
                    w_next      = S_HALT;
                end
            end
            S_WB: begin
                w_dec_vld = 1'b1;
                regwr     = w_dec.regwr;
                pc_wr     = 1'b1;
                w_next    = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_fault_set) r_fault <= 1'b1;
            if (w_next != r_state)
                r_wait <= '0;
            else if (r_state == S_FETCH || r_state == S_MEM)
                r_wait <= r_wait + TO_W'(1);
        end
    end

    assign w_dec_g = w_dec_vld ? w_dec : '0;
    assign extop   = w_dec_g.extop;
    assign ALUAsrc = w_dec_g.alua;
    assign ALUBsrc = w_dec_g.alub;
    assign ALUctr  = w_dec_g.aluctr;
    assign branch  = w_dec_g.branch;
    assign mem2reg = w_dec_g.mem2reg;
    assign memop   = w_dec_g.memop;
    assign fault   = r_fault;
    assign state   = r_state;

endmodule
